// File: rtl/region_fit_counter.sv
// Counts how many rectangular regions can hold their listed shapes, checking either
// total cell area or whole-tile capacity, with one record entering a 4-stage pipeline every BEATS cycles.
module region_fit_counter #(
    parameter int NUM_SHAPES = 6,
    parameter int DIM_W      = 8,
    parameter int CNT_W      = 8,
    parameter int BEAT_W     = 32,
    parameter int SHAPE_AREA = 9,
    parameter int TILE       = 3,
    parameter int CNT_OUT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_OUT_W-1:0] num_regions,
    input  logic                 mode,
    input  logic [BEAT_W-1:0]    data_in,
    input  logic                 valid_in,
    output logic                 ready,
    output logic [CNT_OUT_W-1:0] fit_count,
    output logic [CNT_OUT_W-1:0] fail_count,
    output logic                 finished
);
    localparam int RECORD_W  = 2*DIM_W + NUM_SHAPES*CNT_W;
    localparam int BEATS     = (RECORD_W + BEAT_W - 1) / BEAT_W;
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BUF_N     = (BEATS > 1) ? BEATS - 1 : 1;
    localparam int NUM_PAIRS = (NUM_SHAPES + 1) / 2;
    localparam int PAIR_W    = CNT_W + 1;
    localparam int SUM_W     = CNT_W + ((NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1);
    localparam int PROD_W    = 2*DIM_W;
    localparam int REQ_W     = SUM_W + $clog2(SHAPE_AREA + 1);
    localparam int CMP_W     = (REQ_W > PROD_W) ? REQ_W : PROD_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic [IDX_W-1:0]     beat_idx_reg;
    logic [CNT_OUT_W-1:0] rec_cnt_reg, num_regions_reg;
    logic                 mode_reg;
    logic [BEAT_W-1:0]    beat_buf_reg [BUF_N];
    logic [BEATS*BEAT_W-1:0] full_rec;

    logic start_acc, accept, rec_done, last_record;

    assign ready       = (state_reg == RUN);
    assign finished    = (state_reg == DONE);
    assign start_acc   = start && (state_reg == IDLE || state_reg == DONE);
    assign accept      = valid_in && ready;
    assign rec_done    = accept && (beat_idx_reg == IDX_W'(BEATS - 1));
    assign last_record = (rec_cnt_reg + CNT_OUT_W'(1)) == num_regions_reg;

    // Pipeline valids, stage registers
    logic                rec_valid_reg, s1_valid_reg, s2_valid_reg, s3_valid_reg, s4_valid_reg;
    logic [RECORD_W-1:0] rec_reg;
    logic [DIM_W-1:0]    s1_w_reg, s1_h_reg;
    logic [CNT_W-1:0]    s1_shape_reg [NUM_SHAPES];
    logic [PROD_W-1:0]   s2_prod_reg, s2_tiles_reg, s3_prod_reg, s3_tiles_reg;
    logic [PAIR_W-1:0]   s2_pair_reg [NUM_PAIRS];
    logic [PAIR_W-1:0]   pair_next [NUM_PAIRS];
    logic [SUM_W-1:0]    s3_sum_reg, sum_next;
    logic                s4_fit_reg, fit_next;
    logic [CMP_W-1:0]    req_area;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = (num_regions == '0) ? DONE : RUN;
            RUN:        if (rec_done && last_record) state_next = DRAIN;
            // Nothing enters in DRAIN, so the retiring record is the last one once the earlier stages are empty.
            DRAIN:      if (s4_valid_reg && !rec_valid_reg && !s1_valid_reg && !s2_valid_reg && !s3_valid_reg)
                            state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            beat_idx_reg    <= '0;
            rec_cnt_reg     <= '0;
            num_regions_reg <= '0;
            mode_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                beat_idx_reg    <= '0;
                rec_cnt_reg     <= '0;
                num_regions_reg <= num_regions;
                mode_reg        <= mode;
            end else if (accept) begin
                beat_idx_reg <= rec_done ? '0 : beat_idx_reg + IDX_W'(1);
                if (rec_done) rec_cnt_reg <= rec_cnt_reg + CNT_OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_N; i++) beat_buf_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < BUF_N; i++)
                if (beat_idx_reg == IDX_W'(i)) beat_buf_reg[i] <= data_in;
        end
    end

    // Earlier beats come from the buffer; the final beat is taken straight off data_in.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_asm
            if (gi == BEATS - 1) begin : g_last
                assign full_rec[gi*BEAT_W +: BEAT_W] = data_in;
            end else begin : g_prev
                assign full_rec[gi*BEAT_W +: BEAT_W] = beat_buf_reg[gi];
            end
        end
        for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
            if (2*gi + 1 < NUM_SHAPES) begin : g_two
                assign pair_next[gi] = PAIR_W'(s1_shape_reg[2*gi]) + PAIR_W'(s1_shape_reg[2*gi+1]);
            end else begin : g_one
                assign pair_next[gi] = PAIR_W'(s1_shape_reg[2*gi]);
            end
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NUM_PAIRS; i++) sum_next = sum_next + SUM_W'(s2_pair_reg[i]);
    end

    always_comb begin
        req_area = CMP_W'(s3_sum_reg) * CMP_W'(SHAPE_AREA);
        fit_next = mode_reg ? (CMP_W'(s3_sum_reg) <= CMP_W'(s3_tiles_reg))
                            : (req_area <= CMP_W'(s3_prod_reg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            s4_valid_reg  <= 1'b0;
        end else begin
            rec_valid_reg <= rec_done;
            s1_valid_reg  <= rec_valid_reg;
            s2_valid_reg  <= s1_valid_reg;
            s3_valid_reg  <= s2_valid_reg;
            s4_valid_reg  <= s3_valid_reg;
        end
    end

    always_ff @(posedge clk) begin
        rec_reg  <= full_rec[RECORD_W-1:0];
        s1_w_reg <= rec_reg[DIM_W-1:0];
        s1_h_reg <= rec_reg[2*DIM_W-1:DIM_W];
        for (int i = 0; i < NUM_SHAPES; i++) s1_shape_reg[i] <= rec_reg[2*DIM_W + i*CNT_W +: CNT_W];
        s2_prod_reg  <= PROD_W'(s1_w_reg) * PROD_W'(s1_h_reg);
        s2_tiles_reg <= PROD_W'(s1_w_reg / DIM_W'(TILE)) * PROD_W'(s1_h_reg / DIM_W'(TILE));
        for (int i = 0; i < NUM_PAIRS; i++) s2_pair_reg[i] <= pair_next[i];
        s3_sum_reg   <= sum_next;
        s3_prod_reg  <= s2_prod_reg;
        s3_tiles_reg <= s2_tiles_reg;
        s4_fit_reg   <= fit_next;
    end

    // Result counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            fit_count  <= '0;
            fail_count <= '0;
        end else if (s4_valid_reg) begin
            if (s4_fit_reg && fit_count != '1)   fit_count  <= fit_count + CNT_OUT_W'(1);
            if (!s4_fit_reg && fail_count != '1) fail_count <= fail_count + CNT_OUT_W'(1);
        end
    end
endmodule

// File: tb/tb_region_fit_counter.sv
// Bench for region_fit_counter: table of single-region runs, hand sequences for multi-cycle corners,
// and a scoreboard that checks every retirement's outcome and 5-cycle latency.
module tb_region_fit_counter;
    localparam int NS = 6, DW = 8, CW = 8, BW = 32, CO = 32;
    localparam int RW = 2*DW + NS*CW;
    localparam int NB = (RW + BW - 1) / BW;

    logic          clk = 1'b0;
    logic          rst, start, mode, valid_in, ready, finished;
    logic [CO-1:0] num_regions, fit_count, fail_count;
    logic [BW-1:0] data_in;

    always #5 clk = ~clk;

    region_fit_counter dut (
        .clk(clk), .rst(rst), .start(start), .num_regions(num_regions), .mode(mode),
        .data_in(data_in), .valid_in(valid_in), .ready(ready),
        .fit_count(fit_count), .fail_count(fail_count), .finished(finished)
    );

    typedef struct { logic exp_fit; int due; } sb_t;
    typedef struct {
        logic           m;
        logic [DW-1:0]  w, h;
        logic [NS*CW-1:0] s;
        logic           exp_fit;
    } vec_t;

    sb_t           sb_q[$];
    int            n_tests = 0, n_fail = 0, cyc = 0;
    logic [CO-1:0] prev_fit = '0, prev_fail = '0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic model_fit(input logic m, input int w, input int h, input logic [NS*CW-1:0] s);
        int sum = 0;
        for (int i = 0; i < NS; i++) sum += int'(s[i*CW +: CW]);
        if (!m) return (sum * 9) <= (w * h);
        return sum <= ((w / 3) * (h / 3));
    endfunction

    // Retirement monitor: any counter movement must match the oldest queued record, on its due cycle.
    always begin : mon
        sb_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (mon_en) begin
            if (fit_count !== prev_fit || fail_count !== prev_fail) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_update", {fit_count, fail_count}, {prev_fit, prev_fail});
                end else begin
                    e = sb_q.pop_front();
                    check("retire_fit", fit_count, prev_fit + CO'(e.exp_fit));
                    check("retire_fail", fail_count, prev_fail + CO'(!e.exp_fit));
                    check("retire_latency", cyc, e.due);
                    $display("[TB] retire cyc=%0d exp_fit=%0d fit=%0d fail=%0d", cyc, e.exp_fit, fit_count, fail_count);
                end
                prev_fit  = fit_count;
                prev_fail = fail_count;
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                check("retire_missing", {fit_count, fail_count},
                      {prev_fit + CO'(e.exp_fit), prev_fail + CO'(!e.exp_fit)});
            end
        end
    end

    task automatic do_reset(input bit with_noise);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        if (with_noise) begin
            start = 1'b1; num_regions = 3; valid_in = 1'b1; data_in = '1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; valid_in = 1'b0;
        sb_q.delete();
        prev_fit = '0; prev_fail = '0;
        mon_en = 1'b1;
    endtask

    task automatic start_run(input logic [CO-1:0] n, input logic m);
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; num_regions = n; mode = m;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; num_regions = '1;
        check("start_clear_fit", fit_count, 0);
        check("start_clear_fail", fail_count, 0);
        check("start_finished", finished, (n == 0));
        prev_fit = '0; prev_fail = '0;
        mon_en = 1'b1;
    endtask

    task automatic send_record(input logic [DW-1:0] w, input logic [DW-1:0] h, input logic [NS*CW-1:0] s,
                               input logic exp_fit, input bit gaps, input int nbeats);
        logic [NB*BW-1:0] padded;
        sb_t e;
        padded = '0;
        padded[RW-1:0] = {s, h, w};
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    valid_in = 1'b0; data_in = $urandom;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = padded[b*BW +: BW];
            check("ready_in_run", ready, 1);
            if (b == NB - 1) begin
                e.exp_fit = exp_fit;
                e.due     = cyc + 6;
                sb_q.push_back(e);
            end
            @(posedge clk);
        end
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_finished(input int budget, output int waited);
        waited = 0;
        while (!finished && waited < budget) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("finished_timeout", finished, 1);
    endtask

    vec_t vecs [14];
    int   waited, exp_fits;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; valid_in = 1'b0; data_in = '0; num_regions = '0;
        vecs[0]  = '{1'b0, 8'd4,   8'd4,   48'h000000000001, 1'b1};
        vecs[1]  = '{1'b0, 8'd3,   8'd3,   48'h000000000101, 1'b0};
        vecs[2]  = '{1'b0, 8'd12,  8'd5,   48'h000000020202, 1'b1};
        vecs[3]  = '{1'b1, 8'd7,   8'd7,   48'h000000000004, 1'b1};
        vecs[4]  = '{1'b1, 8'd7,   8'd7,   48'h000000000302, 1'b0};
        vecs[5]  = '{1'b0, 8'd255, 8'd255, 48'hFFFFFFFFFFFF, 1'b1};
        vecs[6]  = '{1'b0, 8'd0,   8'd0,   48'h000000000000, 1'b1};
        vecs[7]  = '{1'b0, 8'd3,   8'd3,   48'h000000000001, 1'b1};
        vecs[8]  = '{1'b1, 8'd2,   8'd200, 48'h000000000001, 1'b0};
        vecs[9]  = '{1'b1, 8'd255, 8'd255, 48'hFFFFFFFFFFFF, 1'b1};
        vecs[10] = '{1'b0, 8'd10,  8'd9,   48'h000000000505, 1'b1};
        vecs[11] = '{1'b0, 8'd10,  8'd9,   48'h000000010505, 1'b0};
        vecs[12] = '{1'b1, 8'd6,   8'd9,   48'h000000000006, 1'b1};
        vecs[13] = '{1'b1, 8'd0,   8'd255, 48'h000000000000, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b1);
        check("reset_ready", ready, 0);
        check("reset_finished", finished, 0);
        check("reset_fit", fit_count, 0);
        check("reset_fail", fail_count, 0);

        // One single-region run per table entry.
        for (int i = 0; i < 14; i++) begin
            start_run(1, vecs[i].m);
            send_record(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].exp_fit, 1'b0, NB);
            wait_finished(40, waited);
            check($sformatf("vec%0d_fit", i), fit_count, CO'(vecs[i].exp_fit));
            check($sformatf("vec%0d_fail", i), fail_count, CO'(!vecs[i].exp_fit));
            $display("[TB] vec %0d mode=%0d w=%0d h=%0d fit=%0d fail=%0d", i, vecs[i].m, vecs[i].w, vecs[i].h,
                     fit_count, fail_count);
        end

        // Three back-to-back records; extra beats pushed while draining must be ignored.
        start_run(3, 1'b0);
        send_record(8'd4,  8'd4, 48'h000000000001, 1'b1, 1'b0, NB);
        send_record(8'd3,  8'd3, 48'h000000000101, 1'b0, 1'b0, NB);
        send_record(8'd12, 8'd5, 48'h000000020202, 1'b1, 1'b0, NB);
        check("ready_drop_after_last", ready, 0);
        valid_in = 1'b1; data_in = 32'h0000_0303;
        wait_finished(40, waited);
        valid_in = 1'b0;
        check("three_finish_latency", waited, 5);
        check("three_fit", fit_count, 2);
        check("three_fail", fail_count, 1);
        repeat (3) @(posedge clk);
        #2;
        check("done_hold_fit", fit_count, 2);
        check("done_hold_fail", fail_count, 1);
        $display("[TB] run3 fit=%0d fail=%0d latency=%0d", fit_count, fail_count, waited);

        // Empty run goes straight to DONE.
        start_run(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check("zero_ready", ready, 0);
            check("zero_finished", finished, 1);
        end
        $display("[TB] zero run fit=%0d fail=%0d", fit_count, fail_count);

        // Reset in the middle of record 2 of 5, then a fresh run with an ignored start.
        start_run(5, 1'b0);
        send_record(8'd4, 8'd4, 48'h000000000001, 1'b1, 1'b0, NB);
        send_record(8'd4, 8'd4, 48'h000000000001, 1'b1, 1'b0, 1);
        do_reset(1'b1);
        check("midrst_ready", ready, 0);
        check("midrst_finished", finished, 0);
        repeat (8) @(posedge clk);
        #2;
        check("midrst_fit", fit_count, 0);
        check("midrst_fail", fail_count, 0);
        start_run(1, 1'b0);
        @(negedge clk);
        start = 1'b1; num_regions = 7; mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_record(8'd2, 8'd9, 48'h000000000001, 1'b1, 1'b0, NB);
        wait_finished(40, waited);
        check("after_rst_fit", fit_count, 1);
        check("after_rst_fail", fail_count, 0);
        $display("[TB] after reset fit=%0d fail=%0d", fit_count, fail_count);

        // 1000 random records with random valid gaps against the reference model.
        exp_fits = 0;
        mode = 1'($urandom_range(0, 1));
        begin
            logic rmode;
            rmode = mode;
            start_run(1000, rmode);
            for (int r = 0; r < 1000; r++) begin
                logic [DW-1:0] w, h;
                logic [NS*CW-1:0] s;
                logic e;
                if ($urandom_range(0, 7) == 0) begin
                    w = 8'($urandom_range(0, 255)); h = 8'($urandom_range(0, 255));
                    for (int i = 0; i < NS; i++) s[i*CW +: CW] = 8'($urandom_range(0, 255));
                end else begin
                    w = 8'($urandom_range(0, 40)); h = 8'($urandom_range(0, 40));
                    for (int i = 0; i < NS; i++) s[i*CW +: CW] = 8'($urandom_range(0, 7));
                end
                e = model_fit(rmode, int'(w), int'(h), s);
                exp_fits += int'(e);
                send_record(w, h, s, e, 1'b1, NB);
            end
            wait_finished(40, waited);
            check("rand_total", fit_count + fail_count, 1000);
            check("rand_fit", fit_count, exp_fits);
            $display("[TB] random run mode=%0d fit=%0d fail=%0d model_fit=%0d", rmode, fit_count, fail_count, exp_fits);
        end

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/region_fit_counter.md
REGION_FIT_COUNTER -- requirements
Module: region_fit_counter

Interface
REQ-001 SHALL have parameter NUM_SHAPES, default 6: number of per-region shape-count fields.
REQ-002 SHALL have parameter DIM_W, default 8: bit width of region width and height fields.
REQ-003 SHALL have parameter CNT_W, default 8: bit width of each shape-count field.
REQ-004 SHALL have parameter BEAT_W, default 32: input beat width.
REQ-005 SHALL have parameter SHAPE_AREA, default 9: cells per shape in area mode.
REQ-006 SHALL have parameter TILE, default 3: tile edge in tile mode.
REQ-007 SHALL have parameter CNT_OUT_W, default 32: result counter width.
REQ-008 clk  input  1  clock; all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 start  input  1  one-cycle pulse that begins a run.
REQ-011 num_regions  input  CNT_OUT_W  region count; sampled on accepted start.
REQ-012 mode  input  1  check mode (0 area, 1 tile); sampled on accepted start.
REQ-013 data_in  input  BEAT_W  record beat.
REQ-014 valid_in  input  1  data_in valid.
REQ-015 ready  output  1  beat accepted when valid_in && ready.
REQ-016 fit_count  output  CNT_OUT_W  regions that fit.
REQ-017 fail_count  output  CNT_OUT_W  regions that do not fit.
REQ-018 finished  output  1  high from run completion until next accepted start or reset.

Function
REQ-019 Record SHALL be RECORD_W = 2*DIM_W + NUM_SHAPES*CNT_W bits: width at [DIM_W-1:0], height next, shape i at 2*DIM_W + i*CNT_W.
REQ-020 Record SHALL arrive as BEATS = ceil(RECORD_W/BEAT_W) beats, beat 0 carrying bits [BEAT_W-1:0]; padding bits of the last beat are ignored.
REQ-021 FSM SHALL have states IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-022 IDLE/DONE: start moves to RUN, clears counts, beat index and accepted-record counter, deasserts finished; start SHALL be ignored in RUN and DRAIN.
REQ-023 ready SHALL be 1 only in RUN; no backpressure otherwise inside RUN.
REQ-024 RUN SHALL move to DRAIN in the cycle the record numbered num_regions completes; start with num_regions = 0 SHALL go directly to DONE, finished high the next cycle with counts 0.
REQ-025 Completed record SHALL enter a 4-stage pipeline: unpack; w*h and per-shape partial sums; total sum; required-vs-available compare; counter update one cycle after stage 4.
REQ-026 Area mode: fit iff sum(shape_i)*SHAPE_AREA <= w*h.
REQ-027 Tile mode: fit iff sum(shape_i) <= floor(w/TILE)*floor(h/TILE).
REQ-028 Arithmetic SHALL be unsigned full precision: product 2*DIM_W bits, sum CNT_W+clog2(NUM_SHAPES) bits, required area widened so no truncation occurs.
REQ-029 Each retired record SHALL increment exactly one of fit_count/fail_count; counters saturate at all-ones.
REQ-030 Pipeline SHALL accept a new record every BEATS cycles with no bubbles; back-to-back valid beats SHALL never be dropped.
REQ-031 DRAIN SHALL move to DONE when the last record retires; finished rises in the same cycle as the final counter update becomes visible.
REQ-032 Latency from acceptance of a record's final beat to its counter update SHALL be 5 cycles.
REQ-033 fit_count and fail_count SHALL hold their values in DONE until the next accepted start.

Reset
REQ-034 rst SHALL force IDLE, ready=0, finished=0, fit_count=0, fail_count=0, and clear beat index, pipeline valids and captured partial beats.
REQ-035 rst mid-run SHALL discard partial records and in-flight pipeline contents; no counter update follows reset.
REQ-036 rst SHALL dominate start and valid_in in the same cycle.

Verification
REQ-037 Defaults, mode 0, num_regions=3, records (w=4,h=4,counts 1,0,0,0,0,0), (w=3,h=3,counts 1,1,...), (w=12,h=5,counts 2,2,2,0,0,0) -> fit_count=2, fail_count=1, finished 5 cycles after last beat.
REQ-038 Mode 1, w=7,h=7 (4 tiles): total 4 -> fit; total 5 -> fail; w=255,h=255, all counts 255 in mode 0 -> 13770 <= 65025 fit with no overflow.
REQ-039 num_regions=0 start -> finished=1 next cycle, counts 0, ready never asserted.
REQ-040 valid_in toggled randomly, 1000 records -> fit+fail=1000, matches reference model; ready drops after final beat; extra beats ignored.
REQ-041 rst asserted after first beat of record 2 of 5, then new start with num_regions=1 -> counts reflect only the new run; start pulsed during RUN ignored.
